// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative multiply/divide unit that owns the HI/LO registers.
//
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring, one quotient bit
// per cycle) over 32 CALC cycles, followed by one FIX cycle for sign correction.
// MTHI/MTLO write HI/LO directly when the unit is idle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   issue request, sampled only while busy=0
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a      in   rs operand (multiplicand/dividend, MTHI/MTLO source)
//   b      in   rt operand (multiplier/divisor)
//   busy   out  high while a MULT/DIV is in progress (33 cycles)
//   done   out  one-cycle pulse when HI/LO have just been written by MULT/DIV
//   hi/lo  out  architectural HI/LO registers
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;         // product / quotient must be negated
    logic        rem_neg_q, rem_neg_d; // remainder takes the dividend's sign
    logic        div0_q, div0_d;
    logic [31:0] a_q, a_d;             // original dividend, returned on divide by zero
    logic [31:0] mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic [31:0] acc_hi_q, acc_hi_d;   // partial product high / partial remainder
    logic [31:0] acc_lo_q, acc_lo_d;   // multiplier bits / dividend bits -> quotient
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic [63:0] prod, prod_neg;

    // Signed ops (op[0]=0) work on magnitudes; |0x80000000| stays 0x80000000.
    assign a_neg = ~op[0] & a[31];
    assign b_neg = ~op[0] & b[31];
    assign mag_a = a_neg ? (~a + 32'd1) : a;
    assign mag_b = b_neg ? (~b + 32'd1) : b;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign div_shift = {acc_hi_q, acc_lo_q[31]};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_neg = ~prod + 64'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        a_d       = a_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d   = StCalc;
                            cnt_d     = 5'd0;
                            is_div_d  = op[1];
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = a_neg;
                            div0_d    = op[1] & (b == 32'd0);
                            a_d       = a;
                            acc_hi_d  = 32'd0;
                            if (op[1]) begin
                                acc_lo_d = mag_a;
                                mcand_d  = mag_b;
                            end else begin
                                acc_lo_d = mag_b;
                                mcand_d  = mag_a;
                            end
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    // Restoring step: keep the difference only if it did not go negative.
                    if (!div_diff[32]) begin
                        acc_hi_d = div_diff[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (div0_q) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else if (is_div_q) begin
                    lo_d = neg_q     ? (~acc_lo_q + 32'd1) : acc_lo_q;
                    hi_d = rem_neg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? prod_neg : prod;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            a_q       <= 32'd0;
            mcand_q   <= 32'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            a_q       <= a_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mips_cpu_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     r;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = 64'd0;
        case (o)
            3'd0: begin sq = sx * sy; r = sq; end
            3'd1: begin uq = ux * uy; r = uq; end
            3'd2: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else begin
                    uq = ux / uy;
                    ur = ux % uy;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Reference model: cycles of busy remaining and the pending result.
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_res = 64'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (op < 3'd4) begin
                    m_res = ref_result(op, a, b);
                    m_cnt = 33;
                end else if (op == 3'd4) m_hi = a;
                else if (op == 3'd5) m_lo = a;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy === (m_cnt > 0) && done === m_done && hi === m_hi && lo === m_lo)
                passes++;
            else
                $display("FAIL cycle t=%0t busy=%b want %b done=%b want %b hi=%h want %h lo=%h want %h",
                         $time, busy, (m_cnt > 0), done, m_done, hi, m_hi, lo, m_lo);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts busy cycles (bounded); returns at the negedge where busy has dropped.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) chk("timeout_busy", 64'(n), 64'd33);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;

        // Pin the model itself on hand-computed values.
        chk("model_multu", ref_result(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_mult",  ref_result(3'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_div",   ref_result(3'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_divu0", ref_result(3'd3, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
        chk("model_divov", ref_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF),
            64'h0000_0000_8000_0000);

        // Reset.
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_state", {busy, done, hi, lo}, 66'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU with latency measurement.
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("multu_busy_cycles", 64'(n), 64'd33);
        chk("multu_done", {63'd0, done}, 64'd1);
        chk("multu_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        chk("mult_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(3'd3, 32'd100, 32'd0);
        wait_done(n);
        chk("divu_by_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

        // MTHI while idle.
        @(negedge clk);
        issue(3'd4, 32'h1234_5678, 32'd0);
        chk("mthi", {busy, done, hi}, {2'b00, 32'h1234_5678});

        // Requests while busy are ignored.
        issue(3'd1, 32'd6, 32'd7);
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd3);
        wait_done(n);
        chk("ignored_while_busy", {hi, lo}, 64'd42);

        // Back-to-back issue on the done cycle.
        issue(3'd3, 32'd50, 32'd7);
        chk("b2b_accept", {63'd0, busy}, 64'd1);
        wait_done(n);
        chk("b2b_result", {hi, lo}, {32'd1, 32'd7});

        // Reset in the middle of CALC.
        issue(3'd0, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_mid_op", {busy, done, hi, lo}, 66'd0);
        repeat (40) @(negedge clk);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            a     = rnd_opnd();
            b     = rnd_opnd();
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
